// File: rtl/mgt01_int_regfile_pkg.sv
// Shared MicroGT-01 types: architectural register names and the integer data bus.
package Instruction_pkg;

   typedef enum logic [4:0] {
      X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
      X8,  X9,  X10, X11, X12, X13, X14, X15,
      X16, X17, X18, X19, X20, X21, X22, X23,
      X24, X25, X26, X27, X28, X29, X30, X31
   } i_register_e;

endpackage

package Modules_pkg;

   typedef logic [31:0] data_bus_t;

   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/mgt01_int_regfile_read_port.sv
// One combinational read port: register select, x0 masking and writeback forwarding.
module mgt01_regfile_read_port
   import Instruction_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 32,
   parameter int WRITE_FIRST = 1
) (
   input  logic                       rst_i,
   input  logic                       we_i,
   input  logic [4:0]                 raddr_i,
   input  logic [4:0]                 waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [NUM_REGS*DATA_W-1:0] regs_flat_i,
   output logic [DATA_W-1:0]          rdata_o
);

   logic fwd_hit;

   // Forwarding never applies to x0 or while reset is clearing the array.
   assign fwd_hit = (WRITE_FIRST != 0) && we_i && !rst_i &&
                    (waddr_i == raddr_i) && (i_register_e'(raddr_i) != X0);

   always_comb begin
      rdata_o = regs_flat_i[int'(raddr_i)*DATA_W +: DATA_W];
      if (i_register_e'(raddr_i) == X0) begin
         rdata_o = '0;
      end else if (fwd_hit) begin
         rdata_o = wdata_i;
      end
   end

endmodule

// File: rtl/mgt01_int_regfile.sv
// RV32I integer register file: x1..x31 storage, one synchronous write port, two read ports.
module mgt01_int_regfile
   import Instruction_pkg::*;
#(
   parameter int DATA_W      = Modules_pkg::DATA_W,
   parameter int NUM_REGS    = Modules_pkg::NUM_REGS,
   parameter int WRITE_FIRST = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [4:0]        r1_iaddr_i,
   input  logic [4:0]        r2_iaddr_i,
   input  logic [4:0]        w_iaddr_i,
   input  logic [DATA_W-1:0] wr_idata_i,
   output logic [DATA_W-1:0] r1_idata_o,
   output logic [DATA_W-1:0] r2_idata_o
);

   logic [DATA_W-1:0]          regs [1:NUM_REGS-1];
   logic [NUM_REGS*DATA_W-1:0] regs_flat;

   // Reset wins over a coincident write; writes to x0 have nowhere to land.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && (i_register_e'(w_iaddr_i) != X0)) begin
         regs[w_iaddr_i] <= wr_idata_i;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         regs_flat[i*DATA_W +: DATA_W] = regs[i];
      end
   end

   mgt01_regfile_read_port #(
      .DATA_W      (DATA_W),
      .NUM_REGS    (NUM_REGS),
      .WRITE_FIRST (WRITE_FIRST)
   ) u_rd1 (
      .rst_i       (rst_i),
      .we_i        (we_i),
      .raddr_i     (r1_iaddr_i),
      .waddr_i     (w_iaddr_i),
      .wdata_i     (wr_idata_i),
      .regs_flat_i (regs_flat),
      .rdata_o     (r1_idata_o)
   );

   mgt01_regfile_read_port #(
      .DATA_W      (DATA_W),
      .NUM_REGS    (NUM_REGS),
      .WRITE_FIRST (WRITE_FIRST)
   ) u_rd2 (
      .rst_i       (rst_i),
      .we_i        (we_i),
      .raddr_i     (r2_iaddr_i),
      .waddr_i     (w_iaddr_i),
      .wdata_i     (wr_idata_i),
      .regs_flat_i (regs_flat),
      .rdata_o     (r2_idata_o)
   );

endmodule

// File: tb/tb_mgt01_int_regfile.sv
// Directed bench for mgt01_int_regfile with WRITE_FIRST=1.
module tb_mgt01_int_regfile;

   logic        clk_i;
   logic        rst_i;
   logic        we_i;
   logic [4:0]  r1_iaddr_i;
   logic [4:0]  r2_iaddr_i;
   logic [4:0]  w_iaddr_i;
   logic [31:0] wr_idata_i;
   logic [31:0] r1_idata_o;
   logic [31:0] r2_idata_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mgt01_int_regfile #(
      .DATA_W      (32),
      .NUM_REGS    (32),
      .WRITE_FIRST (1)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (we_i),
      .r1_iaddr_i (r1_iaddr_i),
      .r2_iaddr_i (r2_iaddr_i),
      .w_iaddr_i  (w_iaddr_i),
      .wr_idata_i (wr_idata_i),
      .r1_idata_o (r1_idata_o),
      .r2_idata_o (r2_idata_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk_i);
      we_i       = 1'b1;
      w_iaddr_i  = addr;
      wr_idata_i = data;
      @(posedge clk_i);
      #1;
      we_i = 1'b0;
   endtask

   task automatic test_reset;
      do_write(5'd3, 32'h1234_5678);
      do_write(5'd17, 32'hCAFE_F00D);
      do_write(5'd31, 32'hFFFF_FFFF);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int a = 0; a < 32; a++) begin
         r1_iaddr_i = 5'(a);
         r2_iaddr_i = 5'(31 - a);
         #1;
         total_cnt++;
         if (r1_idata_o !== 32'h0) $display("FAIL reset_r1 addr=%0d got=%h exp=%h", a, r1_idata_o, 32'h0);
         else pass_cnt++;
         total_cnt++;
         if (r2_idata_o !== 32'h0) $display("FAIL reset_r2 addr=%0d got=%h exp=%h", 31 - a, r2_idata_o, 32'h0);
         else pass_cnt++;
      end
   endtask

   task automatic test_x0_write;
      @(negedge clk_i);
      we_i       = 1'b1;
      w_iaddr_i  = 5'd0;
      wr_idata_i = 32'd500;
      r1_iaddr_i = 5'd0;
      r2_iaddr_i = 5'd0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'h0) $display("FAIL x0_pre_r1 got=%h exp=%h", r1_idata_o, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (r2_idata_o !== 32'h0) $display("FAIL x0_pre_r2 got=%h exp=%h", r2_idata_o, 32'h0);
      else pass_cnt++;
      @(posedge clk_i);
      #1;
      we_i = 1'b0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'h0) $display("FAIL x0_post_r1 got=%h exp=%h", r1_idata_o, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (r2_idata_o !== 32'h0) $display("FAIL x0_post_r2 got=%h exp=%h", r2_idata_o, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_basic_write;
      do_write(5'd1, 32'd1000);
      r1_iaddr_i = 5'd1;
      r2_iaddr_i = 5'd0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd1000) $display("FAIL basic_r1 got=%0d exp=%0d", r1_idata_o, 1000);
      else pass_cnt++;
      total_cnt++;
      if (r2_idata_o !== 32'd0) $display("FAIL basic_r2 got=%0d exp=%0d", r2_idata_o, 0);
      else pass_cnt++;
   endtask

   task automatic test_read_during_write;
      @(negedge clk_i);
      we_i       = 1'b1;
      w_iaddr_i  = 5'd1;
      wr_idata_i = 32'd2000;
      r1_iaddr_i = 5'd1;
      r2_iaddr_i = 5'd0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd2000) $display("FAIL fwd_r1 got=%0d exp=%0d", r1_idata_o, 2000);
      else pass_cnt++;
      total_cnt++;
      if (r2_idata_o !== 32'd0) $display("FAIL fwd_r2_x0 got=%0d exp=%0d", r2_idata_o, 0);
      else pass_cnt++;
      // Both ports hitting the written register forward together.
      r2_iaddr_i = 5'd1;
      #1;
      total_cnt++;
      if (r2_idata_o !== 32'd2000) $display("FAIL fwd_r2_same got=%0d exp=%0d", r2_idata_o, 2000);
      else pass_cnt++;
      @(posedge clk_i);
      #1;
      we_i       = 1'b0;
      r2_iaddr_i = 5'd0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd2000) $display("FAIL fwd_post_r1 got=%0d exp=%0d", r1_idata_o, 2000);
      else pass_cnt++;
   endtask

   task automatic test_write_disabled;
      @(negedge clk_i);
      we_i       = 1'b0;
      w_iaddr_i  = 5'd1;
      wr_idata_i = 32'd200;
      r1_iaddr_i = 5'd1;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd2000) $display("FAIL wdis_pre got=%0d exp=%0d", r1_idata_o, 2000);
      else pass_cnt++;
      @(posedge clk_i);
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd2000) $display("FAIL wdis_post got=%0d exp=%0d", r1_idata_o, 2000);
      else pass_cnt++;
   endtask

   task automatic test_all_regs;
      logic [31:0] exp1;
      logic [31:0] exp2;
      for (int i = 1; i < 32; i++) begin
         do_write(5'(i), 32'(i * 7 + 3));
      end
      for (int i = 0; i < 32; i++) begin
         r1_iaddr_i = 5'(i);
         r2_iaddr_i = 5'(31 - i);
         exp1 = (i == 0) ? 32'd0 : 32'(i * 7 + 3);
         exp2 = (i == 31) ? 32'd0 : 32'((31 - i) * 7 + 3);
         #1;
         total_cnt++;
         if (r1_idata_o !== exp1) $display("FAIL all_r1 addr=%0d got=%0d exp=%0d", i, r1_idata_o, exp1);
         else pass_cnt++;
         total_cnt++;
         if (r2_idata_o !== exp2) $display("FAIL all_r2 addr=%0d got=%0d exp=%0d", 31 - i, r2_idata_o, exp2);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_during_write;
      // x5 holds 38 from the previous fill.
      @(negedge clk_i);
      rst_i      = 1'b1;
      we_i       = 1'b1;
      w_iaddr_i  = 5'd5;
      wr_idata_i = 32'hDEAD_BEEF;
      r1_iaddr_i = 5'd5;
      r2_iaddr_i = 5'd9;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd38) $display("FAIL rstw_nofwd got=%h exp=%h", r1_idata_o, 32'd38);
      else pass_cnt++;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      we_i  = 1'b0;
      #1;
      total_cnt++;
      if (r1_idata_o !== 32'd0) $display("FAIL rstw_dropped got=%h exp=%h", r1_idata_o, 32'd0);
      else pass_cnt++;
      total_cnt++;
      if (r2_idata_o !== 32'd0) $display("FAIL rstw_other got=%h exp=%h", r2_idata_o, 32'd0);
      else pass_cnt++;
   endtask

   initial begin
      rst_i      = 1'b1;
      we_i       = 1'b0;
      r1_iaddr_i = 5'd0;
      r2_iaddr_i = 5'd0;
      w_iaddr_i  = 5'd0;
      wr_idata_i = 32'd0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      test_reset();
      test_x0_write();
      test_basic_write();
      test_read_during_write();
      test_write_disabled();
      test_all_regs();
      test_reset_during_write();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mgt01_int_regfile.md
Name: mgt01_int_regfile

Overview:
- RV32I integer register file for the MicroGT-01 core: 32 registers x 32 bits (x0..x31), two combinational read ports and one synchronous write port.
- Sits between decode (operand read) and writeback (result write).
- x0 is hardwired to zero.
- Write-to-read forwarding lets a value written in writeback be read by decode in the same cycle.

Parameters:
- DATA_W, 32, register and data-bus width; must equal width of data_bus_t.
- NUM_REGS, 32, number of architectural registers; address width is log2(NUM_REGS) = 5.
- WRITE_FIRST, 1, 1 = same-cycle read of the register being written returns wr_idata_i; 0 = read returns old contents.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- we_i  in  1  write enable.
- r1_iaddr_i  in  5 (i_register_e)  read port 1 address.
- r2_iaddr_i  in  5 (i_register_e)  read port 2 address.
- w_iaddr_i  in  5 (i_register_e)  write address.
- wr_idata_i  in  32 (data_bus_t)  write data.
- r1_idata_o  out  32 (data_bus_t)  read port 1 data.
- r2_idata_o  out  32 (data_bus_t)  read port 2 data.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Storage: registers x1..x31, DATA_W bits each. x0 has no storage.

Reset:
- At a rising edge with rst_i=1, x1..x31 clear to 0.
- Reset has priority over a simultaneous write, so the write is dropped.
- Outputs follow from the cleared contents (0 for any address) once the reset edge has occurred.

Write:
- At a rising edge with rst_i=0, we_i=1 and w_iaddr_i != X0: register[w_iaddr_i] <= wr_idata_i.
- A write to X0 is silently discarded.
- With we_i=0, no register changes, whatever the address/data.
- Write latency: 1 edge.

Read:
- Purely combinational, zero latency: r1_idata_o = value(r1_iaddr_i), r2_idata_o = value(r2_iaddr_i).
- Address X0 always reads 32'h0, including during a write to X0.

Forwarding (WRITE_FIRST=1):
- If we_i=1 and w_iaddr_i == rN_iaddr_i and the address != X0, then rN_idata_o = wr_idata_i in the same cycle.
- Forwarding is suppressed while rst_i=1.
- Both read ports forward independently; both may hit the same address.

Other rules:
- WRITE_FIRST=0: reads return stored contents; new data is visible after the edge.
- No X propagation: every register has a defined value after the first reset.
- Contents are undefined before the first reset.
- No handshake, no stall, no error outputs.

Decomposition:
- Shared package (Instruction_pkg) holds i_register_e: 5-bit enum X0..X31.
- Shared package (Modules_pkg) holds data_bus_t (logic [31:0]) and the DATA_W/NUM_REGS constants.
- One optional sub-module, mgt01_regfile_read_port (address decode + x0 masking + forward mux), instantiated twice.
- Storage array and write logic stay in the top.

Test Plan:
- Reset: assert rst_i one cycle after arbitrary writes -> every address reads 0 on r1/r2.
- x0 write: we=1, w=X0, data=500, then read r1=r2=X0 -> both outputs 0 before and after the edge.
- Basic write: we=1, w=X1, data=1000, one edge, then r1=X1, r2=X0 -> r1=1000, r2=0.
- Read-during-write: X1 holds 1000, we=1, w=X1, data=2000, r1=X1 in the same cycle -> r1=2000 immediately (WRITE_FIRST=1; 1000 if 0), and 2000 after the edge; r2=X0 -> 0.
- Write disabled: we=0, w=X1, data=200, r1=X1 -> r1 stays 2000 across the edge.
- Dual-port/all registers: write i*7+3 to x1..x31, read every pair (r1=i, r2=31-i) -> expected values, with x0 = 0; reset during a write -> write dropped, register = 0.
